alu_mul_sequencer: RTL

- Multi-cycle controller that uses the shared 16-bit ALU to do an unsigned 16x16 -> 32-bit multiply by shift-and-add.
- Sits beside the ALU. It drives the ALU's A, B and control inputs and samples its Result and Carry.
- Gives the core a multiply without a second adder or a hardware multiplier.
- Handshake: start / busy / done.

---
 rtl/alu_mul_sequencer.sv | 114 +++++++++++
 1 files changed

// File: rtl/alu_mul_sequencer.sv
// Shift-and-add 16x16->32 unsigned multiply sequenced through the shared ALU.
// Optional early termination: define ALU_MUL_SEQ_EARLY_TERM_EN.
module alu_mul_sequencer #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] prod_hi,
  output logic [WIDTH-1:0] prod_lo,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic [2:0]       alu_ctrl,
  input  logic [WIDTH-1:0] alu_result,
  input  logic             alu_carry
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  localparam logic [4:0] LAST = 5'(WIDTH - 1);

  state_t           state, state_nxt;
  logic [WIDTH-1:0] mcand, mp, acc, lo;
  logic [4:0]       cnt;
  logic [WIDTH-1:0] acc_nxt, lo_nxt;

  // The ALU carry becomes the new top bit, so the 17-bit sum is never truncated.
  assign acc_nxt = {alu_carry, alu_result[WIDTH-1:1]};
  assign lo_nxt  = {alu_result[0], lo[WIDTH-1:1]};

`ifdef ALU_MUL_SEQ_EARLY_TERM_EN
  logic [5:0]         shamt;
  logic [2*WIDTH-1:0] shifted;
  // Remaining iterations would only add zero and shift, so collapse them.
  assign shamt   = 6'(WIDTH) - {1'b0, cnt};
  assign shifted = {acc, lo} >> shamt;
`endif

  // NOTE: every output of this block gets a default first, so no path can infer a latch.
  always_comb begin
    state_nxt = state;
    alu_a     = '0;
    alu_b     = '0;
    alu_ctrl  = 3'b000;
    busy      = (state != IDLE);
    done      = (state == DONE);
    case (state)
      IDLE: if (start) state_nxt = RUN;
      RUN: begin
`ifdef ALU_MUL_SEQ_EARLY_TERM_EN
        if (mp == '0) state_nxt = DONE;
        else
`endif
        begin
          alu_a = acc;
          alu_b = mp[0] ? mcand : '0;
          if (cnt == LAST) state_nxt = DONE;
        end
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // NOTE: state is updated with non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= IDLE;
      mcand   <= '0;
      mp      <= '0;
      acc     <= '0;
      lo      <= '0;
      cnt     <= '0;
      prod_hi <= '0;
      prod_lo <= '0;
    end else begin
      state <= state_nxt;
      case (state)
        IDLE: if (start) begin
          mcand <= op_a;
          mp    <= op_b;
          acc   <= '0;
          lo    <= '0;
          cnt   <= '0;
        end
        RUN: begin
`ifdef ALU_MUL_SEQ_EARLY_TERM_EN
          if (mp == '0) begin
            {acc, lo}         <= shifted;
            {prod_hi, prod_lo} <= shifted;
          end else
`endif
          begin
            acc <= acc_nxt;
            lo  <= lo_nxt;
            mp  <= mp >> 1;
            cnt <= cnt + 5'd1;
            // Product is published on the edge that enters DONE.
            if (cnt == LAST) begin
              prod_hi <= acc_nxt;
              prod_lo <= lo_nxt;
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule
